crash_detector: RTL and testbench
=================================

Name: crash_detector

Overview:
- Produces the `crash` input that `player_controller` samples on `game_tick[0]`, i.e. the opposite direction of the controller interface.
- Watches the rendered pixel stream for coincident player and obstacle pixels, filters out glitches over a whole frame, and applies a start-of-game grace period.
- Holds `crash` until the controller acknowledges it with `game_over_pulse`.
- Sits between the sprite renderers and `player_controller`, and also reports where the first overlap was seen.

Parameters:
- MIN_OVERLAP_PIXELS, 4: overlapping pixels needed in one frame to declare a crash (>=1).
- GRACE_FRAMES, 8: frames after `game_start_pulse` during which overlaps are ignored (0 = none).
- COORD_W, 10: width of `hpos`/`vpos`.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- game_tick  in  2  [1] = one-cycle end-of-frame strobe; [0] = controller sample strobe (unused internally)
- video_active  in  1  current pixel is in the visible area
- hpos  in  COORD_W  current pixel x
- vpos  in  COORD_W  current pixel y
- player_pixel  in  1  player sprite opaque at current pixel
- obstacle_pixel  in  1  any obstacle opaque at current pixel
- game_start_pulse  in  1  one cycle; game (re)started
- game_over_pulse  in  1  one cycle; controller acknowledged the crash
- crash  out  1  registered; high from crash frame until acknowledged
- crash_hpos  out  COORD_W  x of first overlap pixel in the crash frame
- crash_vpos  out  COORD_W  y of first overlap pixel in the crash frame
- armed  out  1  registered; high in ARMED

Behaviour:
- **Reset** (reset low, async): state=IDLE; crash=0; armed=0; crash_hpos/crash_vpos=0; overlap count, first-hit flag and grace counter=0.
- **Overlap event**: `hit = video_active & player_pixel & obstacle_pixel`.
- **Overlap counter**:
  - Width $clog2(MIN_OVERLAP_PIXELS+1).
  - Increments on `hit`, saturates at MIN_OVERLAP_PIXELS.
  - Cleared on every `game_tick[1]` and on every state change.
- **First-hit capture**: on the first `hit` of a frame (first-hit flag clear), capture hpos/vpos into shadow registers and set the flag. The flag clears on `game_tick[1]`.
- **Same-cycle hit and tick**: a `hit` in the same cycle as `game_tick[1]` counts toward the frame ending now. Evaluate the threshold against count+1, and use the current hpos/vpos as the first hit if none has been captured yet.
- **IDLE**:
  - Overlaps ignored.
  - `game_start_pulse` -> GRACE with grace counter = GRACE_FRAMES, or -> ARMED if GRACE_FRAMES==0.
- **GRACE**:
  - Overlaps ignored.
  - Each `game_tick[1]` decrements the grace counter; the tick that takes it 1->0 moves to ARMED.
- **ARMED**:
  - armed=1.
  - On `game_tick[1]`: if count (including the same-cycle hit) >= MIN_OVERLAP_PIXELS -> CRASHED. In the same edge, set crash=1 and load crash_hpos/vpos from the shadow registers.
  - Otherwise stay in ARMED and clear the count.
- **CRASHED**:
  - crash held at 1; overlaps ignored; crash_hpos/vpos frozen.
  - `game_over_pulse` -> IDLE; crash=0 on that edge.
- **game_start_pulse priority**:
  - In GRACE, ARMED or CRASHED: restart to GRACE (or ARMED if GRACE_FRAMES==0), clear crash, reload the grace counter.
  - Wins over a simultaneous `game_tick[1]` and over `game_over_pulse`.
- **game_over_pulse** outside CRASHED: ignored.
- **Latency**: crash rises on the clock edge that samples the frame-ending `game_tick[1]`. It is therefore valid at the next `game_tick[0]`.
- **Reset mid-frame**: all partial counts are discarded and the state returns to IDLE.

Decomposition:
- Shared package (`dino_pkg`):
  - state encoding localparams: IDLE=2'b00, GRACE=2'b01, ARMED=2'b10, CRASHED=2'b11;
  - COORD_W default;
  - the `game_tick` bit-index constants TICK_VEL=0 and TICK_POS=1, shared with `player_controller`.
- One natural sub-module, `overlap_accumulator`: saturating counter plus first-hit capture, with `clear` and `hit` inputs. The FSM stays in `crash_detector`.

Test Plan:
- Reset, start, GRACE_FRAMES=8: overlaps of 10 pixels in each of frames 1-8 -> crash stays 0; armed rises after the 8th `game_tick[1]`.
- ARMED, frame with 3 overlapping pixels (MIN=4) -> no crash. Next frame with 4 pixels, first at (120,200) -> crash=1 on the `game_tick[1]` edge; crash_hpos=120, crash_vpos=200.
- ARMED, 3 hits, then a 4th hit in the same cycle as `game_tick[1]` -> crash=1 on that edge.
- CRASHED, further overlaps at other coordinates -> crash_hpos/vpos unchanged. `game_over_pulse` -> crash=0 next edge, state IDLE. A later overlap with no start -> crash stays 0.
- CRASHED, `game_start_pulse` and `game_over_pulse` in the same cycle -> GRACE, crash=0, grace counter=8.
- Assert reset low mid-frame while in ARMED with count=3 -> crash=0 and armed=0 immediately. After release and start with GRACE_FRAMES=0, a 3-hit frame -> no crash.

Source files
------------

// File: rtl/dino_pkg.sv
// Shared definitions for the dino game datapath.
// - state_t      : crash_detector FSM encoding (IDLE, GRACE, ARMED, CRASHED)
// - COORD_W_DEFAULT : default pixel coordinate width
// - TICK_VEL/TICK_POS : bit indices into game_tick, shared with player_controller
package dino_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    GRACE   = 2'b01,
    ARMED   = 2'b10,
    CRASHED = 2'b11
  } state_t;

  localparam int COORD_W_DEFAULT = 10;

  localparam int TICK_VEL = 0;
  localparam int TICK_POS = 1;

endpackage

// File: rtl/crash_detector_if.sv
// Bundle between the sprite renderers / player_controller and crash_detector.
// Pixel stream and game control flow into the detector; crash status flows out.
//   game_tick[1:0], video_active, hpos, vpos, player_pixel, obstacle_pixel,
//   game_start_pulse, game_over_pulse  : driven by master
//   crash, crash_hpos, crash_vpos, armed : driven by slave (crash_detector)
interface crash_detector_if
  import dino_pkg::*;
#(
  parameter int COORD_W = COORD_W_DEFAULT
);

  logic [1:0]         game_tick;
  logic               video_active;
  logic [COORD_W-1:0] hpos;
  logic [COORD_W-1:0] vpos;
  logic               player_pixel;
  logic               obstacle_pixel;
  logic               game_start_pulse;
  logic               game_over_pulse;
  logic               crash;
  logic [COORD_W-1:0] crash_hpos;
  logic [COORD_W-1:0] crash_vpos;
  logic               armed;

  modport master (
    output game_tick, video_active, hpos, vpos, player_pixel, obstacle_pixel,
           game_start_pulse, game_over_pulse,
    input  crash, crash_hpos, crash_vpos, armed
  );

  modport slave (
    input  game_tick, video_active, hpos, vpos, player_pixel, obstacle_pixel,
           game_start_pulse, game_over_pulse,
    output crash, crash_hpos, crash_vpos, armed
  );

endinterface

// File: rtl/crash_detector_overlap_accumulator.sv
// Per-frame overlap accumulator: saturating hit counter plus capture of the
// first hit coordinate in the frame.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   clear             : end of frame / restart; discards count and first-hit flag
//   hit, hpos, vpos   : overlap event and its pixel coordinate
//   frame_met         : threshold reached counting a hit in this very cycle
//   first_hpos/vpos   : first hit of the frame, or the current pixel if none yet
module overlap_accumulator
  import dino_pkg::*;
#(
  parameter int MIN_OVERLAP_PIXELS = 4,
  parameter int COORD_W            = COORD_W_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               hit,
  input  logic [COORD_W-1:0] hpos,
  input  logic [COORD_W-1:0] vpos,
  output logic               frame_met,
  output logic [COORD_W-1:0] first_hpos,
  output logic [COORD_W-1:0] first_vpos
);

  localparam int CNT_W = $clog2(MIN_OVERLAP_PIXELS + 1);

  logic [CNT_W-1:0]   count;
  logic               have_first;
  logic [COORD_W-1:0] shadow_h;
  logic [COORD_W-1:0] shadow_v;
  logic [CNT_W:0]     count_incl;

  // A hit coinciding with the frame-end clear still belongs to the ending
  // frame, so the threshold and first-hit outputs fold it in combinationally.
  always_comb begin
    count_incl = {1'b0, count} + {{CNT_W{1'b0}}, hit};
    frame_met  = (count_incl >= (CNT_W + 1)'(MIN_OVERLAP_PIXELS));
    first_hpos = have_first ? shadow_h : hpos;
    first_vpos = have_first ? shadow_v : vpos;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count      <= '0;
      have_first <= 1'b0;
    end else if (clear) begin
      count      <= '0;
      have_first <= 1'b0;
    end else if (hit) begin
      if (count != CNT_W'(MIN_OVERLAP_PIXELS)) begin
        count <= count + CNT_W'(1);
      end
      have_first <= 1'b1;
    end
  end

  // Coordinates are only meaningful while have_first is set, so no reset.
  always_ff @(posedge clk) begin
    if (hit && !have_first && !clear) begin
      shadow_h <= hpos;
      shadow_v <= vpos;
    end
  end

endmodule

// File: rtl/crash_detector.sv
// Crash detector: counts coincident player/obstacle pixels per frame and
// raises crash when a frame reaches MIN_OVERLAP_PIXELS, after a start-of-game
// grace period. crash holds until the controller acknowledges it.
// Ports:
//   clk   : system clock
//   reset : asynchronous, active-low reset
//   bus   : crash_detector_if.slave (pixel stream, tick/start/over strobes in;
//           crash, crash_hpos, crash_vpos, armed out)
module crash_detector
  import dino_pkg::*;
#(
  parameter int MIN_OVERLAP_PIXELS = 4,
  parameter int GRACE_FRAMES       = 8,
  parameter int COORD_W            = COORD_W_DEFAULT
) (
  input  logic           clk,
  input  logic           reset,
  crash_detector_if.slave bus
);

  localparam int     GRACE_W     = (GRACE_FRAMES > 0) ? $clog2(GRACE_FRAMES + 1) : 1;
  localparam state_t START_STATE = (GRACE_FRAMES == 0) ? ARMED : GRACE;

  state_t             state;
  logic [GRACE_W-1:0] grace_cnt;
  logic               crash_r;
  logic               armed_r;
  logic [COORD_W-1:0] crash_h_r;
  logic [COORD_W-1:0] crash_v_r;

  logic               hit;
  logic               tick;
  logic               start;
  logic               ack;
  logic               acc_clear;
  logic               frame_met;
  logic [COORD_W-1:0] first_h;
  logic [COORD_W-1:0] first_v;
  logic               unused_vel;

  assign hit        = bus.video_active & bus.player_pixel & bus.obstacle_pixel;
  assign tick       = bus.game_tick[TICK_POS];
  assign start      = bus.game_start_pulse;
  assign ack        = bus.game_over_pulse;
  assign unused_vel = bus.game_tick[TICK_VEL];

  // Every state change happens on a tick, a start or an acknowledge, so
  // clearing on those covers both frame boundaries and state changes.
  assign acc_clear = tick | start | ((state == CRASHED) & ack);

  overlap_accumulator #(
    .MIN_OVERLAP_PIXELS (MIN_OVERLAP_PIXELS),
    .COORD_W            (COORD_W)
  ) u_accum (
    .clk        (clk),
    .rst_n      (reset),
    .clear      (acc_clear),
    .hit        (hit & (state == ARMED)),
    .hpos       (bus.hpos),
    .vpos       (bus.vpos),
    .frame_met  (frame_met),
    .first_hpos (first_h),
    .first_vpos (first_v)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      grace_cnt <= '0;
      crash_r   <= 1'b0;
      armed_r   <= 1'b0;
      crash_h_r <= '0;
      crash_v_r <= '0;
    end else if (start) begin
      // A start restarts the game from any state, overriding tick and ack.
      state     <= START_STATE;
      grace_cnt <= GRACE_W'(GRACE_FRAMES);
      crash_r   <= 1'b0;
      armed_r   <= (START_STATE == ARMED);
    end else begin
      case (state)
        IDLE: ;
        GRACE: begin
          if (tick) begin
            grace_cnt <= grace_cnt - GRACE_W'(1);
            if (grace_cnt == GRACE_W'(1)) begin
              state   <= ARMED;
              armed_r <= 1'b1;
            end
          end
        end
        ARMED: begin
          if (tick && frame_met) begin
            state     <= CRASHED;
            crash_r   <= 1'b1;
            armed_r   <= 1'b0;
            crash_h_r <= first_h;
            crash_v_r <= first_v;
          end
        end
        CRASHED: begin
          if (ack) begin
            state   <= IDLE;
            crash_r <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          crash_r <= 1'b0;
          armed_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.crash      = crash_r;
  assign bus.armed      = armed_r;
  assign bus.crash_hpos = crash_h_r;
  assign bus.crash_vpos = crash_v_r;

endmodule

// File: tb/tb_crash_detector.sv
// Bench for crash_detector: two instances (GRACE_FRAMES=8 and 0) share clock
// and reset; directed scenarios plus a randomized run against a frame-level
// reference model.
module tb_crash_detector;
  import dino_pkg::*;

  localparam int CW  = 10;
  localparam int MIN = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Per-instance stimulus (index 0: GRACE_FRAMES=8, index 1: GRACE_FRAMES=0)
  logic [1:0]    tick_i [2];
  logic          va_i   [2];
  logic          pp_i   [2];
  logic          op_i   [2];
  logic          st_i   [2];
  logic          go_i   [2];
  logic [CW-1:0] h_i    [2];
  logic [CW-1:0] v_i    [2];

  logic          o_crash [2];
  logic          o_armed [2];
  logic [CW-1:0] o_ch    [2];
  logic [CW-1:0] o_cv    [2];

  crash_detector_if #(.COORD_W(CW)) ifa ();
  crash_detector_if #(.COORD_W(CW)) ifb ();

  assign ifa.game_tick = tick_i[0];  assign ifb.game_tick = tick_i[1];
  assign ifa.video_active = va_i[0]; assign ifb.video_active = va_i[1];
  assign ifa.player_pixel = pp_i[0]; assign ifb.player_pixel = pp_i[1];
  assign ifa.obstacle_pixel = op_i[0]; assign ifb.obstacle_pixel = op_i[1];
  assign ifa.game_start_pulse = st_i[0]; assign ifb.game_start_pulse = st_i[1];
  assign ifa.game_over_pulse = go_i[0];  assign ifb.game_over_pulse = go_i[1];
  assign ifa.hpos = h_i[0]; assign ifb.hpos = h_i[1];
  assign ifa.vpos = v_i[0]; assign ifb.vpos = v_i[1];
  assign o_crash[0] = ifa.crash; assign o_crash[1] = ifb.crash;
  assign o_armed[0] = ifa.armed; assign o_armed[1] = ifb.armed;
  assign o_ch[0] = ifa.crash_hpos; assign o_ch[1] = ifb.crash_hpos;
  assign o_cv[0] = ifa.crash_vpos; assign o_cv[1] = ifb.crash_vpos;

  crash_detector #(.MIN_OVERLAP_PIXELS(MIN), .GRACE_FRAMES(8), .COORD_W(CW)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa.slave));
  crash_detector #(.MIN_OVERLAP_PIXELS(MIN), .GRACE_FRAMES(0), .COORD_W(CW)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb.slave));

  int n_cmp  = 0;
  int n_fail = 0;

  // ---------------- reference model (frame level) ----------------
  bit m_run [2];
  bit m_crashed [2];
  int m_grace [2];
  int m_hits [2];
  int m_fh [2], m_fv [2], m_ch [2], m_cv [2];

  function automatic int grace_of(int d);
    return (d == 0) ? 8 : 0;
  endfunction

  function automatic bit m_armed(int d);
    return m_run[d] && !m_crashed[d] && (m_grace[d] == 0);
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_run[d] = 0; m_crashed[d] = 0; m_grace[d] = 0; m_hits[d] = 0;
      m_fh[d] = 0; m_fv[d] = 0; m_ch[d] = 0; m_cv[d] = 0;
    end
  endtask

  task automatic model_step(int d);
    bit hit;
    bit t;
    hit = va_i[d] & pp_i[d] & op_i[d];
    t   = tick_i[d][TICK_POS];
    if (st_i[d]) begin
      m_run[d] = 1; m_crashed[d] = 0; m_grace[d] = grace_of(d); m_hits[d] = 0;
    end else if (m_crashed[d]) begin
      if (go_i[d]) begin m_run[d] = 0; m_crashed[d] = 0; end
      m_hits[d] = 0;
    end else if (m_run[d] && m_grace[d] > 0) begin
      if (t) m_grace[d] = m_grace[d] - 1;
      m_hits[d] = 0;
    end else if (m_run[d]) begin
      if (hit) begin
        if (m_hits[d] == 0) begin m_fh[d] = int'(h_i[d]); m_fv[d] = int'(v_i[d]); end
        m_hits[d] = m_hits[d] + 1;
      end
      if (t) begin
        if (m_hits[d] >= MIN) begin
          m_crashed[d] = 1; m_ch[d] = m_fh[d]; m_cv[d] = m_fv[d];
        end
        m_hits[d] = 0;
      end
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic clear_inputs();
    for (int d = 0; d < 2; d++) begin
      tick_i[d] = 2'b00; va_i[d] = 0; pp_i[d] = 0; op_i[d] = 0;
      st_i[d] = 0; go_i[d] = 0; h_i[d] = '0; v_i[d] = '0;
    end
  endtask

  // Advance one clock: model consumes the inputs the DUT is about to sample.
  task automatic cycle();
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(int d);
    st_i[d] = 1; cycle(); st_i[d] = 0;
  endtask

  task automatic pulse_over(int d);
    go_i[d] = 1; cycle(); go_i[d] = 0;
  endtask

  task automatic hits(int d, int n, int h0, int v0);
    for (int i = 0; i < n; i++) begin
      va_i[d] = 1; pp_i[d] = 1; op_i[d] = 1;
      h_i[d] = CW'(h0 + i); v_i[d] = CW'(v0);
      cycle();
    end
    pp_i[d] = 1; op_i[d] = 0;
    cycle();
    va_i[d] = 0; pp_i[d] = 0;
    cycle();
  endtask

  // n hits on one row, then the end-of-frame tick (optionally carrying a hit)
  task automatic frame(int d, int n, int h0, int v0, bit tick_hit);
    hits(d, n, h0, v0);
    tick_i[d][TICK_POS] = 1;
    if (tick_hit) begin
      va_i[d] = 1; pp_i[d] = 1; op_i[d] = 1;
      h_i[d] = CW'(h0 + n); v_i[d] = CW'(v0);
    end
    cycle();
    tick_i[d][TICK_POS] = 0; va_i[d] = 0; pp_i[d] = 0; op_i[d] = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    @(negedge clk);
    reset = 0;
    model_reset();
    @(negedge clk);
    reset = 1;
    cycle();
  endtask

  task automatic reset_mid();
    #2;
    reset = 0;
    model_reset();
    #1;
  endtask

  task automatic release_reset();
    clear_inputs();
    @(negedge clk);
    reset = 1;
    cycle();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    clear_inputs();
    reset = 0;
    model_reset();
    #13;
    for (int d = 0; d < 2; d++) begin
      n_cmp++; if (o_crash[d] !== 1'b0) begin n_fail++; $display("FAIL reset_crash[%0d]: got %0b need 0", d, o_crash[d]); end
      n_cmp++; if (o_armed[d] !== 1'b0) begin n_fail++; $display("FAIL reset_armed[%0d]: got %0b need 0", d, o_armed[d]); end
      n_cmp++; if (o_ch[d] !== '0) begin n_fail++; $display("FAIL reset_hpos[%0d]: got %0d need 0", d, o_ch[d]); end
      n_cmp++; if (o_cv[d] !== '0) begin n_fail++; $display("FAIL reset_vpos[%0d]: got %0d need 0", d, o_cv[d]); end
    end
    @(negedge clk);
    reset = 1;
    cycle();
  endtask

  task automatic test_grace();
    pulse_start(0);
    n_cmp++; if (o_armed[0] !== 1'b0) begin n_fail++; $display("FAIL grace_start_armed: got %0b need 0", o_armed[0]); end
    for (int f = 1; f <= 8; f++) begin
      frame(0, 10, 100, 100, 0);
      n_cmp++; if (o_crash[0] !== 1'b0) begin n_fail++; $display("FAIL grace_crash f%0d: got %0b need 0", f, o_crash[0]); end
      n_cmp++; if (o_armed[0] !== (f == 8)) begin n_fail++; $display("FAIL grace_armed f%0d: got %0b need %0b", f, o_armed[0], (f == 8)); end
    end
  endtask

  task automatic test_threshold();
    frame(0, 3, 50, 60, 0);
    n_cmp++; if (o_crash[0] !== 1'b0) begin n_fail++; $display("FAIL thr3_crash: got %0b need 0", o_crash[0]); end
    n_cmp++; if (o_armed[0] !== 1'b1) begin n_fail++; $display("FAIL thr3_armed: got %0b need 1", o_armed[0]); end
    hits(0, 4, 120, 200);
    n_cmp++; if (o_crash[0] !== 1'b0) begin n_fail++; $display("FAIL thr4_before_tick: got %0b need 0", o_crash[0]); end
    tick_i[0][TICK_POS] = 1; cycle(); tick_i[0][TICK_POS] = 0;
    n_cmp++; if (o_crash[0] !== 1'b1) begin n_fail++; $display("FAIL thr4_crash: got %0b need 1", o_crash[0]); end
    n_cmp++; if (o_ch[0] !== CW'(120)) begin n_fail++; $display("FAIL thr4_hpos: got %0d need 120", o_ch[0]); end
    n_cmp++; if (o_cv[0] !== CW'(200)) begin n_fail++; $display("FAIL thr4_vpos: got %0d need 200", o_cv[0]); end
    n_cmp++; if (o_armed[0] !== 1'b0) begin n_fail++; $display("FAIL thr4_armed: got %0b need 0", o_armed[0]); end
  endtask

  task automatic test_crashed_hold();
    frame(0, 5, 300, 50, 0);
    n_cmp++; if (o_crash[0] !== 1'b1) begin n_fail++; $display("FAIL hold_crash: got %0b need 1", o_crash[0]); end
    n_cmp++; if (o_ch[0] !== CW'(120)) begin n_fail++; $display("FAIL hold_hpos: got %0d need 120", o_ch[0]); end
    n_cmp++; if (o_cv[0] !== CW'(200)) begin n_fail++; $display("FAIL hold_vpos: got %0d need 200", o_cv[0]); end
    pulse_over(0);
    n_cmp++; if (o_crash[0] !== 1'b0) begin n_fail++; $display("FAIL ack_crash: got %0b need 0", o_crash[0]); end
    n_cmp++; if (o_armed[0] !== 1'b0) begin n_fail++; $display("FAIL ack_armed: got %0b need 0", o_armed[0]); end
    frame(0, 6, 10, 10, 0);
    n_cmp++; if (o_crash[0] !== 1'b0) begin n_fail++; $display("FAIL idle_crash: got %0b need 0", o_crash[0]); end
    pulse_over(0);
    n_cmp++; if (o_armed[0] !== 1'b0) begin n_fail++; $display("FAIL idle_over_armed: got %0b need 0", o_armed[0]); end
  endtask

  task automatic test_same_cycle();
    pulse_start(1);
    n_cmp++; if (o_armed[1] !== 1'b1) begin n_fail++; $display("FAIL g0_armed: got %0b need 1", o_armed[1]); end
    frame(1, 3, 40, 60, 1);
    n_cmp++; if (o_crash[1] !== 1'b1) begin n_fail++; $display("FAIL tickhit_crash: got %0b need 1", o_crash[1]); end
    n_cmp++; if (o_ch[1] !== CW'(40)) begin n_fail++; $display("FAIL tickhit_hpos: got %0d need 40", o_ch[1]); end
    n_cmp++; if (o_cv[1] !== CW'(60)) begin n_fail++; $display("FAIL tickhit_vpos: got %0d need 60", o_cv[1]); end
    pulse_over(1);
    // Only hit of the frame arrives with the tick: it is the first hit
    pulse_start(1);
    frame(1, 0, 9, 9, 1);
    n_cmp++; if (o_crash[1] !== 1'b0) begin n_fail++; $display("FAIL tickonly_crash: got %0b need 0", o_crash[1]); end
    pulse_over(1);
  endtask

  task automatic test_start_over_priority();
    pulse_start(0);
    for (int f = 0; f < 8; f++) frame(0, 0, 0, 0, 0);
    n_cmp++; if (o_armed[0] !== 1'b1) begin n_fail++; $display("FAIL prio_armed: got %0b need 1", o_armed[0]); end
    frame(0, 4, 77, 88, 0);
    n_cmp++; if (o_crash[0] !== 1'b1) begin n_fail++; $display("FAIL prio_crash: got %0b need 1", o_crash[0]); end
    st_i[0] = 1; go_i[0] = 1; cycle(); st_i[0] = 0; go_i[0] = 0;
    n_cmp++; if (o_crash[0] !== 1'b0) begin n_fail++; $display("FAIL prio_crash_clr: got %0b need 0", o_crash[0]); end
    n_cmp++; if (o_armed[0] !== 1'b0) begin n_fail++; $display("FAIL prio_armed_clr: got %0b need 0", o_armed[0]); end
    for (int f = 1; f <= 8; f++) begin
      frame(0, 10, 200, 20, 0);
      n_cmp++; if (o_armed[0] !== (f == 8)) begin n_fail++; $display("FAIL regrace_armed f%0d: got %0b need %0b", f, o_armed[0], (f == 8)); end
      n_cmp++; if (o_crash[0] !== 1'b0) begin n_fail++; $display("FAIL regrace_crash f%0d: got %0b need 0", f, o_crash[0]); end
    end
  endtask

  task automatic test_reset_mid();
    hits(0, 3, 5, 5);
    reset_mid();
    n_cmp++; if (o_armed[0] !== 1'b0) begin n_fail++; $display("FAIL mid_armed: got %0b need 0", o_armed[0]); end
    n_cmp++; if (o_crash[0] !== 1'b0) begin n_fail++; $display("FAIL mid_crash: got %0b need 0", o_crash[0]); end
    release_reset();
    pulse_start(1);
    hits(1, 3, 30, 30);
    reset_mid();
    release_reset();
    pulse_start(1);
    frame(1, 1, 31, 31, 0);
    n_cmp++; if (o_crash[1] !== 1'b0) begin n_fail++; $display("FAIL mid_discard_crash: got %0b need 0", o_crash[1]); end
    n_cmp++; if (o_armed[1] !== 1'b1) begin n_fail++; $display("FAIL mid_discard_armed: got %0b need 1", o_armed[1]); end
    frame(1, 3, 32, 32, 0);
    n_cmp++; if (o_crash[1] !== 1'b0) begin n_fail++; $display("FAIL mid_3hit_crash: got %0b need 0", o_crash[1]); end
    frame(1, 4, 33, 34, 0);
    n_cmp++; if (o_crash[1] !== 1'b1) begin n_fail++; $display("FAIL mid_4hit_crash: got %0b need 1", o_crash[1]); end
    n_cmp++; if (o_ch[1] !== CW'(33)) begin n_fail++; $display("FAIL mid_4hit_hpos: got %0d need 33", o_ch[1]); end
  endtask

  task automatic test_random();
    int dens [2];
    do_reset();
    dens[0] = 2; dens[1] = 2;
    for (int n = 0; n < 4000; n++) begin
      for (int d = 0; d < 2; d++) begin
        va_i[d] = ($urandom_range(0, 3) != 0);
        pp_i[d] = ($urandom_range(0, 15) < dens[d]);
        op_i[d] = ($urandom_range(0, 15) < 12);
        h_i[d] = CW'($urandom);
        v_i[d] = CW'($urandom);
        tick_i[d][TICK_VEL] = ($urandom_range(0, 7) == 0);
        tick_i[d][TICK_POS] = ($urandom_range(0, 29) == 0);
        st_i[d] = ($urandom_range(0, 299) == 0);
        go_i[d] = ($urandom_range(0, 39) == 0);
        if (tick_i[d][TICK_POS]) dens[d] = $urandom_range(0, 6);
      end
      cycle();
      for (int d = 0; d < 2; d++) begin
        n_cmp++; if (o_crash[d] !== m_crashed[d]) begin n_fail++; $display("FAIL rnd_crash[%0d] n%0d: got %0b need %0b", d, n, o_crash[d], m_crashed[d]); end
        n_cmp++; if (o_armed[d] !== m_armed(d)) begin n_fail++; $display("FAIL rnd_armed[%0d] n%0d: got %0b need %0b", d, n, o_armed[d], m_armed(d)); end
        n_cmp++; if (o_ch[d] !== CW'(m_ch[d])) begin n_fail++; $display("FAIL rnd_hpos[%0d] n%0d: got %0d need %0d", d, n, o_ch[d], m_ch[d]); end
        n_cmp++; if (o_cv[d] !== CW'(m_cv[d])) begin n_fail++; $display("FAIL rnd_vpos[%0d] n%0d: got %0d need %0d", d, n, o_cv[d], m_cv[d]); end
      end
    end
    clear_inputs();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_grace();
    test_threshold();
    test_crashed_hold();
    test_same_cycle();
    test_start_over_priority();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
